// File: rtl/out_allocator_4.sv
// Output-port allocator for a 4-input wormhole crossbar.
// Round-robin arbitration in IDLE, then the winner owns the output until its tail flit is transferred.
module out_allocator_4 #(
    parameter logic [1:0] PTR_RESET = 2'd3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req_in,
    input  logic [3:0] valid_in,
    input  logic [3:0] tail_in,
    input  logic       out_ready,
    output logic [3:0] mux_sel,
    output logic       out_valid,
    output logic [3:0] grant
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;

    logic [1:0] owner;
    logic       owner_valid;
    logic       owner_tail;
    logic       locked;
    logic       xfer;

    logic [3:0] win_oh;
    logic       found;
    logic [1:0] idx;

    always_comb begin
        owner = 2'd0;
        unique case (1'b1)
            mux_sel[0]: owner = 2'd0;
            mux_sel[1]: owner = 2'd1;
            mux_sel[2]: owner = 2'd2;
            mux_sel[3]: owner = 2'd3;
            default:    owner = 2'd0;
        endcase
    end

    assign owner_valid = valid_in[owner];
    assign owner_tail  = tail_in[owner];
    assign locked      = (state == LOCKED);

    assign out_valid = locked & owner_valid;
    assign xfer      = out_valid & out_ready;
    assign grant     = xfer ? mux_sel : 4'b0000;

    // Search starts just past the last winner and wraps modulo 4.
    always_comb begin
        win_oh = 4'b0000;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_in[idx]) begin
                win_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            mux_sel <= 4'b0000;
            ptr     <= PTR_RESET;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_in) begin
                        mux_sel <= win_oh;
                        state   <= LOCKED;
                    end else begin
                        mux_sel <= 4'b0000;
                    end
                end
                LOCKED: begin
                    if (xfer && owner_tail) begin
                        mux_sel <= 4'b0000;
                        ptr     <= owner;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mux_sel <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: doc/out_allocator_4.md
OUT_ALLOCATOR_4 -- requirements
Module: out_allocator_4

Interface
REQ-001 Parameter: PTR_RESET, default 3, round-robin last-winner index loaded at reset; range 0..3, so the default gives input 0 first priority.
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_in  input  4  bit i high = input i holds a head flit routed to this output.
REQ-005 Port: valid_in  input  4  bit i high = input i presents a valid flit.
REQ-006 Port: tail_in  input  4  bit i high = input i's current flit is a tail; a single-flit packet has head = tail.
REQ-007 Port: out_ready  input  1  downstream accepts the flit on the crossbar output this cycle.
REQ-008 Port: mux_sel  output  4  one-hot crossbar select for the 4:1 flit multiplexer; 0 = no owner.
REQ-009 Port: out_valid  output  1  flit on the crossbar output is valid.
REQ-010 Port: grant  output  4  bit i high = input i's flit is consumed this cycle.

Function
REQ-011 The block SHALL implement two states: IDLE (no owner) and LOCKED (owner = index of the single high mux_sel bit).
REQ-012 mux_sel, the state and the round-robin pointer SHALL be registers; out_valid and grant SHALL be combinational from those registers and the inputs.
REQ-013 In IDLE, when req_in != 0, the block SHALL pick the first requesting index in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 The block SHALL load that winner into mux_sel one-hot and enter LOCKED on the next edge; request-to-select latency is 1 cycle.
REQ-015 In IDLE, when req_in == 0, the block SHALL hold mux_sel = 0.
REQ-016 In IDLE, out_valid = 0 and grant = 0.
REQ-017 Arbitration SHALL sample req_in only in the IDLE cycle; a request dropped before that edge is not granted.
REQ-018 In LOCKED, out_valid SHALL equal valid_in[owner].
REQ-019 In LOCKED, grant[owner] SHALL equal valid_in[owner] & out_ready, and all other grant bits SHALL be 0.
REQ-020 In LOCKED, req_in SHALL be ignored, including new req_in from the owner and from other inputs.
REQ-021 A transfer SHALL occur when grant[owner] = 1.
REQ-022 A transfer with tail_in[owner] = 1 SHALL, on that edge, set mux_sel = 0, set ptr = owner and enter IDLE.
REQ-023 A non-tail transfer, or no transfer (valid_in low or out_ready low), SHALL keep LOCKED with mux_sel unchanged, for any number of stall cycles.
REQ-024 Back-to-back packets SHALL incur exactly one IDLE cycle between a tail transfer and the next packet's select.
REQ-025 mux_sel SHALL never have more than one bit set.
REQ-026 tail_in and valid_in of non-owner inputs SHALL have no effect.
REQ-027 ptr SHALL wrap modulo 4: after owner 3, the search starts at 0.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set state = IDLE, mux_sel = 4'b0000 and ptr = PTR_RESET.
REQ-029 The reset values SHALL force out_valid = 0 and grant = 4'b0000 on the following cycle.
REQ-030 Reset asserted mid-packet SHALL abort the lock immediately; the packet remainder is not granted.
REQ-031 Reset SHALL take priority over any simultaneous transfer or arbitration.
REQ-032 Arbitration SHALL resume in the first cycle after reset deasserts.

Verification
REQ-033 Reset, then req_in = 4'b1111 held, every flit valid with tail, out_ready = 1 -> mux_sel sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-034 req_in = 4'b0100 with a 3-flit packet (tail on flit 3), out_ready low for 2 cycles during flit 2 -> mux_sel = 0100 for 5 cycles, grant[2] pulses 3 times, then mux_sel = 0.
REQ-035 While owner = 1, req_in = 4'b1001 asserted -> no change to mux_sel; after owner 1's tail, the next winner is 3 (ptr = 1).
REQ-036 Reset pulsed during flit 2 of 4 from owner 0 -> next cycle mux_sel = 0 and out_valid = 0; with req_in = 4'b1000 the winner is 3, then 0 is preferred next.
REQ-037 Owner valid_in low for 3 cycles with out_ready = 1 -> out_valid = 0, grant = 0, lock held; a valid tail then releases the lock.
REQ-038 Check every cycle -> mux_sel is 0 or one-hot, and grant is a subset of mux_sel.
